// File: rtl/ringosc_pkg.sv
// Shared types and defaults for the ring-oscillator measurement bank.
`timescale 1ns/1ps
package ringosc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_DONE
  } osc_state_t;

  localparam int unsigned SETTLE_CYC_DEF = 8;
  localparam int unsigned SIM_HP_W       = 16;

  // Out-of-range channel requests fall back to channel 0.
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned n_osc);
    return (sel < n_osc) ? sel : 32'd0;
  endfunction

endpackage

// File: rtl/ringosc_cell.sv
// One ring-oscillator channel: NAND-enabled inverting ring plus an
// asynchronously cleared ripple prescaler; o_msb is the divided output.
`timescale 1ns/1ps
module ringosc_cell #(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned DIV_LOG2 = 4,
  parameter int unsigned HALF_PS  = 2000
) (
  input  logic i_rst,
  input  logic i_en,
  output logic o_msb
);

  (* keep = "true", dont_touch = "true" *) logic w_nand;
  logic w_tap;

  for (genvar k = 1; k < STAGES; k++) begin : g_inv
    (* keep = "true", dont_touch = "true" *) logic w_node;
    if (k == 1) begin : g_head
      assign w_node = ~w_nand;
    end else begin : g_tail
      assign w_node = ~g_inv[k-1].w_node;
    end
  end

  assign w_tap = g_inv[STAGES-1].w_node;

`ifdef SYNTHESIS
  assign w_nand = ~(i_en & w_tap);
`else
  // Simulation stand-in for the NAND stage: the whole ring's propagation
  // delay is lumped here so each channel has a fixed, known half-period.
  logic r_nand = 1'b1;
  always begin
    if (i_en) begin
      #(HALF_PS * 1ps);
      r_nand = ~(i_en & w_tap);
    end else begin
      r_nand = 1'b1;
      @(posedge i_en);
    end
  end
  assign w_nand = r_nand;
`endif

  logic [DIV_LOG2-1:0] w_div;

  for (genvar k = 0; k < DIV_LOG2; k++) begin : g_div
    logic r_q;
    logic w_ck;
    if (k == 0) begin : g_first
      assign w_ck = w_tap;
    end else begin : g_next
      assign w_ck = ~w_div[k-1];
    end
    always_ff @(posedge w_ck or posedge i_rst) begin
      if (i_rst) r_q <= 1'b0;
      else       r_q <= ~r_q;
    end
    assign w_div[k] = r_q;
  end

  assign o_msb = w_div[DIV_LOG2-1];

endmodule

// File: rtl/ringosc_bank.sv
// Bank of gated ring oscillators with a gate-window edge counter that
// measures one selected channel per request.
`timescale 1ns/1ps
module ringosc_bank
  import ringosc_pkg::*;
#(
  parameter int unsigned N_OSC      = 4,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned DIV_LOG2   = 4,
  parameter int unsigned GATE_W     = 16,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter logic [N_OSC*SIM_HP_W-1:0] SIM_HALF_PS = {N_OSC{16'd2000}},
  localparam int unsigned SEL_W = (N_OSC > 1) ? $clog2(N_OSC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  osc_sel,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              free_run,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              osc_out
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  osc_state_t        r_state;
  logic [TMR_W-1:0]  r_timer;
  logic [GATE_W-1:0] r_gate;
  logic [N_OSC-1:0]  r_en;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic [1:0]        r_sync;
  logic              r_prev;
  logic [N_OSC-1:0]  w_msb_vec;
  logic              w_msb_sel;
  logic              w_edge;

  function automatic logic [N_OSC-1:0] chan_mask(input logic [SEL_W-1:0] sel);
    logic [N_OSC-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < N_OSC; i++) begin
      m[i] = (i == clamp_sel(32'(sel), N_OSC));
    end
    return m;
  endfunction

  for (genvar i = 0; i < N_OSC; i++) begin : g_cell
    ringosc_cell #(
      .STAGES  (STAGES),
      .DIV_LOG2(DIV_LOG2),
      .HALF_PS (32'(SIM_HALF_PS[i*SIM_HP_W +: SIM_HP_W]))
    ) u_cell (
      .i_rst(rst),
      .i_en (r_en[i]),
      .o_msb(w_msb_vec[i])
    );
  end

  // At most one enable bit is set, so the AND-OR acts as a glitch-free mux.
  assign w_msb_sel = |(w_msb_vec & r_en);
  assign osc_out   = w_msb_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], w_msb_sel};
      r_prev <= r_sync[1];
    end
  end

  assign w_edge = r_sync[1] & ~r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_gate  <= '0;
      r_en    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SETTLE;
            r_en    <= chan_mask(osc_sel);
            r_gate  <= gate_cycles;
            r_timer <= SETTLE_LD;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_en <= free_run ? chan_mask(osc_sel) : '0;
          end
        end
        ST_SETTLE: begin
          if (r_timer == '0) begin
            if (r_gate == '0) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_en    <= '0;
            end else begin
              r_state <= ST_GATE;
              r_timer <= TMR_W'(r_gate) - TMR_ONE;
            end
          end else begin
            r_timer <= r_timer - TMR_ONE;
          end
        end
        ST_GATE: begin
          if (w_edge) begin
            if (r_count == '1) r_ovf   <= 1'b1;
            else               r_count <= r_count + CNT_ONE;
          end
          if (r_timer == '0) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_en    <= '0;
          end else begin
            r_timer <= r_timer - TMR_ONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_ringosc_bank.sv
// Directed bench for ringosc_bank: full-width and 4-bit-counter instances
// share stimulus; channels have distinct ring half-periods.
`timescale 1ns/1ps
module tb_ringosc_bank;

  localparam int unsigned N_OSC = 5;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 20;
  localparam int unsigned SAT_W = 4;
  // ch0 5 ns, ch1 2.5 ns, ch2 1.25 ns, ch3 4 ns, ch4 10 ns half-periods
  localparam logic [N_OSC*16-1:0] HP = {16'd10000, 16'd4000, 16'd1250, 16'd2500, 16'd5000};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              free_run = 1'b0;
  logic [SEL_W-1:0]  osc_sel = '0;
  logic [15:0]       gate_cycles = '0;
  logic              busy, done, overflow, osc_out;
  logic [CNT_W-1:0]  count;
  logic              s_busy, s_done, s_overflow, s_osc_out;
  logic [SAT_W-1:0]  s_count;

  int total = 0;
  int bad = 0;
  int osc_edges = 0;

  always #5 clk = ~clk;
  always @(posedge osc_out) osc_edges++;

  ringosc_bank #(
    .N_OSC(N_OSC), .STAGES(3), .DIV_LOG2(4), .GATE_W(16), .CNT_W(CNT_W),
    .SETTLE_CYC(8), .SIM_HALF_PS(HP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .osc_sel(osc_sel), .gate_cycles(gate_cycles),
    .free_run(free_run), .busy(busy), .done(done), .count(count),
    .overflow(overflow), .osc_out(osc_out)
  );

  ringosc_bank #(
    .N_OSC(N_OSC), .STAGES(3), .DIV_LOG2(4), .GATE_W(16), .CNT_W(SAT_W),
    .SETTLE_CYC(8), .SIM_HALF_PS(HP)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(start), .osc_sel(osc_sel), .gate_cycles(gate_cycles),
    .free_run(free_run), .busy(s_busy), .done(s_done), .count(s_count),
    .overflow(s_overflow), .osc_out(s_osc_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [63:0] obs,
                             input logic [63:0] lo, input logic [63:0] hi);
    total++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Returns at the negedge where done is first seen; lat counts cycles from start.
  task automatic measure(input logic [SEL_W-1:0] sel, input logic [15:0] gate,
                         input bit poke, output int lat);
    osc_sel = sel;
    gate_cycles = gate;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    check("busy_after_start", busy, 1);
    while (done !== 1'b1 && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 300) begin
        start = 1'b1;
        osc_sel = 3'd2;
        gate_cycles = 16'd5;
      end
      if (poke && lat == 301) start = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int e0;
    bit seen_done;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_osc_out", osc_out, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ch1, 1000-cycle gate, with ignored start/sel/gate changes mid-GATE
    measure(3'd1, 16'd1000, 1'b1, lat);
    check("ch1_latency", lat, 1009);
    check_range("ch1_count", count, 124, 126);
    check("ch1_overflow", overflow, 0);
    check("sat_count", s_count, 15);
    check("sat_overflow", s_overflow, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_single_pulse", done, 0);
    check("start_at_done_ignored", busy, 0);
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);
    check_range("idle_count_hold", count, 124, 126);
    check("sat_overflow_hold", s_overflow, 1);

    // zero-length gate
    measure(3'd1, 16'd0, 1'b0, lat);
    check("g0_latency", lat, 9);
    check("g0_count", count, 0);
    check("g0_overflow", overflow, 0);
    check("g0_sat_overflow_cleared", s_overflow, 0);
    check("g0_sat_count", s_count, 0);
    repeat (3) @(negedge clk);

    // out-of-range select falls back to ch0 (12.5 edges per 200 cycles; ch1 would give 25)
    measure(3'd5, 16'd200, 1'b0, lat);
    check("clamp_latency", lat, 209);
    check_range("clamp_count", count, 11, 14);
    repeat (3) @(negedge clk);

    // reset in the middle of GATE
    osc_sel = 3'd1;
    gate_cycles = 16'd1000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_count", count, 0);
    check("midrst_osc_out", osc_out, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
      if (i == 2) rst = 1'b0;
    end
    check("midrst_no_done", seen_done, 0);

    // normal measurement after abort: ch2 gives 25 edges per 100 cycles
    measure(3'd2, 16'd100, 1'b0, lat);
    check("post_rst_latency", lat, 109);
    check_range("post_rst_count", count, 24, 26);
    repeat (3) @(negedge clk);

    // free-running in IDLE: osc_out follows the selected ring divided by 16
    osc_sel = 3'd2;
    free_run = 1'b1;
    repeat (5) @(negedge clk);
    e0 = osc_edges;
    repeat (400) @(negedge clk);
    check_range("free_ch2_edges", osc_edges - e0, 99, 101);
    osc_sel = 3'd3;
    repeat (5) @(negedge clk);
    e0 = osc_edges;
    repeat (400) @(negedge clk);
    check_range("free_ch3_edges", osc_edges - e0, 30, 32);
    free_run = 1'b0;
    repeat (2) @(negedge clk);
    e0 = osc_edges;
    repeat (50) @(negedge clk);
    check("free_off_edges", osc_edges - e0, 0);
    check("free_off_osc_out", osc_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ringosc_bank.md
RINGOSC_BANK -- requirements
Module: ringosc_bank

Interface
REQ-001 SHALL have parameter N_OSC, default 4: number of ring-oscillator channels, 1..16.
REQ-002 SHALL have parameter STAGES, default 3: inverting stages per ring, odd and >=3.
REQ-003 SHALL have parameter DIV_LOG2, default 4: oscillator-domain prescale, output divided by 2^DIV_LOG2.
REQ-004 SHALL have parameter GATE_W, default 16: width of the gate-window length input.
REQ-005 SHALL have parameter CNT_W, default 20: width of the result counter.
REQ-006 SHALL have parameter SETTLE_CYC, default 8: clk cycles allowed for oscillator start and synchroniser fill.
REQ-007 SHALL use one clock and an asynchronous, active-high reset.
REQ-008 clk  in  1  system clock.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 start  in  1  single-cycle measurement request.
REQ-011 osc_sel  in  max(1,$clog2(N_OSC))  channel to measure.
REQ-012 gate_cycles  in  GATE_W  gate-window length in clk cycles.
REQ-013 free_run  in  1  keeps the osc_sel channel enabled while idle.
REQ-014 busy  out  1  high from the cycle after an accepted start until done.
REQ-015 done  out  1  one-cycle pulse when count is valid.
REQ-016 count  out  CNT_W  prescaled edges counted in the last window.
REQ-017 overflow  out  1  count saturated during the last window.
REQ-018 osc_out  out  1  prescaled output of the enabled channel, 0 when none is enabled.

Function
REQ-019 Each channel SHALL be a NAND(enable) ring of STAGES stages, oscillating only while enabled and holding static when disabled.
REQ-020 At most one channel SHALL be enabled at a time: the latched channel in SETTLE/GATE, osc_sel in IDLE when free_run=1, otherwise none.
REQ-021 The prescaler SHALL be a DIV_LOG2-bit ripple toggle counter clocked by the enabled ring, cleared asynchronously by rst.
REQ-022 The prescaler MSB SHALL pass a 2-flop clk-domain synchroniser and a rising-edge detector before counting.
REQ-023 FSM states SHALL be IDLE, SETTLE, GATE and DONE.
REQ-024 IDLE->SETTLE on start=1: latch osc_sel and gate_cycles, clear count and overflow.
REQ-025 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to GATE; no edges are counted.
REQ-026 GATE SHALL last exactly the latched gate_cycles cycles, adding 1 to count per detected edge; gate_cycles=0 SHALL go from SETTLE straight to DONE with count=0.
REQ-027 DONE SHALL last one cycle with done=1, busy=0, then go to IDLE.
REQ-028 count SHALL saturate at 2^CNT_W-1 and set overflow, which is sticky until the next accepted start.
REQ-029 count and overflow SHALL hold their values in IDLE until the next accepted start.
REQ-030 start SHALL be ignored outside IDLE; start coincident with DONE SHALL be ignored.
REQ-031 An out-of-range osc_sel (>=N_OSC) SHALL be clamped to channel 0 at latch time.
REQ-032 Changes of osc_sel or gate_cycles during busy SHALL have no effect.

Reset
REQ-033 rst SHALL force IDLE, busy=0, done=0, count=0, overflow=0, all channels disabled, prescalers and synchronisers 0, and osc_out=0.
REQ-034 rst asserted mid-measurement SHALL abort it without a done pulse; after release the block SHALL accept a new start.

Structure
REQ-035 The FSM state enum and SETTLE_CYC default SHALL live in a shared package ringosc_pkg.
REQ-036 Each channel (ring plus prescaler) SHALL be a sub-module ringosc_cell, generated N_OSC times; the rings SHALL carry keep/dont_touch attributes.
REQ-037 The simulation model of ringosc_cell SHALL offer a per-instance half-period parameter so the ring frequency is deterministic.

Verification
REQ-038 Ch1 half-period 2.5 ns, clk 100 MHz, DIV_LOG2=4, gate_cycles=1000 -> done after 1+8+1000 cycles, count=125+/-1.
REQ-039 gate_cycles=0 -> done pulse exactly SETTLE_CYC+1 cycles after start, count=0, overflow=0.
REQ-040 CNT_W=4, gate_cycles=1000 -> count=15, overflow=1; next start clears overflow.
REQ-041 start pulsed during GATE and at DONE -> ignored, single done pulse, latched channel unchanged.
REQ-042 rst mid-GATE -> busy=0, count=0, osc_out=0 immediately with no done pulse; next start measures normally.
REQ-043 free_run=1, osc_sel=2 in IDLE -> only channel 2 toggles, osc_out at ring/16; osc_sel=5 with N_OSC=4 -> channel 0 measured.
